// File: rtl/foc_pwm_modulator.sv
// -----------------------------------------------------------------------------
// foc_pwm_modulator
//
// N-phase, centre-aligned PWM stage. Turns the per-phase duty words from the FOC
// current controller into complementary high/low gate drive for each half
// bridge. A triangle carrier is compared against each phase's active duty word.
// Duty and period are double buffered and only take effect at the carrier
// valley. The valley strobe (ce_out) paces the controller.
//
// Optional feature macro: FOC_PWM_DEADTIME_EN
//   defined   : per-phase dead-time insertion (DEADTIME clk cycles)
//   undefined : gate_hi = raw compare, gate_lo = inverted raw compare
//
// Parameters
//   NUM_PHASES  number of half-bridge channels
//   PWM_WIDTH   width of carrier counter, period and duty words
//   DEADTIME    dead time in clk cycles (>= 1, only used with the macro)
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   clk_enable  carrier advances only on cycles where this is high
//   pwm_enable  0 forces all gates off on the next edge
//   period      carrier peak value, sampled at the valley
//   duty        packed duty words, phase 0 in the LSBs
//   duty_load   strobe: capture duty into the shadow registers
//   gate_hi     high-side gate per phase, 1 = on
//   gate_lo     low-side gate per phase, 1 = on
//   ce_out      one-clk valley pulse, controller sample tick
// -----------------------------------------------------------------------------
module foc_pwm_modulator #(
  parameter int NUM_PHASES = 3,
  parameter int PWM_WIDTH  = 10,
  parameter int DEADTIME   = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clk_enable,
  input  logic                             pwm_enable,
  input  logic [PWM_WIDTH-1:0]             period,
  input  logic [NUM_PHASES*PWM_WIDTH-1:0]  duty,
  input  logic                             duty_load,
  output logic [NUM_PHASES-1:0]            gate_hi,
  output logic [NUM_PHASES-1:0]            gate_lo,
  output logic                             ce_out
);

  localparam logic [PWM_WIDTH-1:0] CNT_ONE = {{(PWM_WIDTH-1){1'b0}}, 1'b1};

  // A dead time of zero would let both switches of a leg overlap.
  if (DEADTIME < 1) begin : g_deadtime_range
    $error("foc_pwm_modulator: DEADTIME must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Carrier direction FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  dir_t                  dir;
  dir_t                  dir_next;
  logic [PWM_WIDTH-1:0]  cnt;
  logic [PWM_WIDTH-1:0]  cnt_next;
  logic [PWM_WIDTH-1:0]  period_act;
  logic                  valley;

  logic [NUM_PHASES-1:0] raw;
  logic [NUM_PHASES-1:0] hi_next;
  logic [NUM_PHASES-1:0] lo_next;

  // An active period of zero is the reset state and the "parked" state: the
  // valley fires on every enabled cycle so a new period can be picked up.
  // This also makes the first enabled cycle after reset a valley.
  assign valley = clk_enable &&
                  ((period_act == '0) || ((cnt == '0) && (dir == DIR_DOWN)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else begin
      cnt <= cnt_next;
      dir <= dir_next;
    end
  end

  // Sequence for period P: 0(valley),1..P(peak),P-1..1, then valley again,
  // so every value except 0 and P appears twice and the carrier spans 2*P
  // enabled cycles.
  always_comb begin
    cnt_next = cnt;
    dir_next = dir;
    if (valley) begin
      // The counter restarts against the period being loaded on this edge.
      if (period == '0) begin
        cnt_next = '0;
        dir_next = DIR_DOWN;
      end else begin
        cnt_next = CNT_ONE;
        dir_next = DIR_UP;
      end
    end else if (clk_enable) begin
      case (dir)
        DIR_UP: begin
          if (cnt >= period_act) begin
            dir_next = DIR_DOWN;
            cnt_next = cnt - CNT_ONE;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        default: begin
          // cnt==0 while counting down is a valley, handled above.
          cnt_next = cnt - CNT_ONE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Active period and valley strobe
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_act <= '0;
      ce_out     <= 1'b0;
    end else begin
      ce_out <= valley;
      if (valley) begin
        period_act <= period;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-phase duty buffering, compare and gate drive
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_phase
    logic [PWM_WIDTH-1:0] duty_in;
    logic [PWM_WIDTH-1:0] shadow;
    logic [PWM_WIDTH-1:0] duty_act;

    assign duty_in = duty[gi*PWM_WIDTH +: PWM_WIDTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        shadow <= '0;
      end else if (duty_load) begin
        shadow <= duty_in;
      end
    end

    // A load that lands exactly on the valley bypasses the shadow so the
    // controller never loses a whole carrier period of latency.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        duty_act <= '0;
      end else if (valley) begin
        duty_act <= duty_load ? duty_in : shadow;
      end
    end

    // duty >= period must give a solid high even at the peak sample where
    // cnt == period; a zero period parks the leg low.
    assign raw[gi] = (period_act != '0) &&
                     ((duty_act >= period_act) || (cnt < duty_act));

`ifdef FOC_PWM_DEADTIME_EN
    localparam int                 DT_W    = $clog2(DEADTIME + 1);
    localparam logic [DT_W-1:0]    DT_LAST = DT_W'(DEADTIME - 1);

    logic            raw_q;
    logic [DT_W-1:0] stable_cnt;
    logic            settled;

    // stable_cnt counts clk cycles (not carrier steps) in which raw has
    // matched its previous value. After a change the gates stay off for
    // exactly DEADTIME cycles; a pulse shorter than that never turns a
    // gate on at all.
    assign settled = (raw[gi] == raw_q) && (stable_cnt >= DT_LAST);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        raw_q      <= 1'b0;
        stable_cnt <= '0;
      end else begin
        raw_q <= raw[gi];
        if (raw[gi] != raw_q) begin
          stable_cnt <= '0;
        end else if (stable_cnt < DT_LAST) begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end
    end

    // The dead-time tracker keeps running while pwm_enable is low, so a
    // re-enable can only turn on a gate whose raw level is already settled.
    assign hi_next[gi] = pwm_enable &&  raw[gi] && settled;
    assign lo_next[gi] = pwm_enable && !raw[gi] && settled;
`else
    assign hi_next[gi] = pwm_enable &&  raw[gi];
    assign lo_next[gi] = pwm_enable && !raw[gi];
`endif
  end

  // Both gates come from the same raw bit with opposite polarity, so a
  // shoot-through combination cannot be registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_hi <= '0;
      gate_lo <= '0;
    end else begin
      gate_hi <= hi_next;
      gate_lo <= lo_next;
    end
  end

endmodule

// File: tb/tb_foc_pwm_modulator.sv
// -----------------------------------------------------------------------------
// tb_foc_pwm_modulator
//
// Self-checking bench for foc_pwm_modulator. A behavioural reference model
// describes the carrier as a position within a 2*P-step triangle and derives
// the compare, double buffering, valley strobe and optional dead time from
// that. Stimulus is mostly randomised with $urandom. One line per failed
// comparison, one summary line at the end.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_foc_pwm_modulator;

  localparam int NP = 3;
  localparam int W  = 10;
  localparam int D  = 3;

  logic          clk;
  logic          rst;
  logic          clk_enable;
  logic          pwm_enable;
  logic [W-1:0]  period;
  logic [NP*W-1:0] duty;
  logic          duty_load;
  logic [NP-1:0] gate_hi;
  logic [NP-1:0] gate_lo;
  logic          ce_out;

  int n_checks = 0;
  int n_fail   = 0;

  foc_pwm_modulator #(
    .NUM_PHASES(NP),
    .PWM_WIDTH (W),
    .DEADTIME  (D)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .clk_enable(clk_enable),
    .pwm_enable(pwm_enable),
    .period    (period),
    .duty      (duty),
    .duty_load (duty_load),
    .gate_hi   (gate_hi),
    .gate_lo   (gate_lo),
    .ce_out    (ce_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // m_pos is the position inside the carrier: 0 is the valley, m_pact the
  // peak, and the carrier value is the triangle folded at the peak.
  // ---------------------------------------------------------------------------
  int          m_pos;
  int          m_pact;
  int          m_shadow [NP];
  int          m_dact   [NP];
  logic [NP-1:0] m_gh;
  logic [NP-1:0] m_gl;
  logic        m_ce;
  logic [NP-1:0] m_hist [$];

  function automatic int duty_word(int k);
    logic [W-1:0] w;
    w = duty[k*W +: W];
    return int'(w);
  endfunction

  function automatic int model_cnt();
    return (m_pos <= m_pact) ? m_pos : 2*m_pact - m_pos;
  endfunction

  task automatic model_reset();
    m_pos  = 0;
    m_pact = 0;
    for (int k = 0; k < NP; k++) begin
      m_shadow[k] = 0;
      m_dact[k]   = 0;
    end
    m_gh = '0;
    m_gl = '0;
    m_ce = 1'b0;
    m_hist = {};
    m_hist.push_back('0);
  endtask

  task automatic model_step();
    int            c;
    logic [NP-1:0] r;
    bit            v;
    bit            ok;
    c = model_cnt();
    for (int k = 0; k < NP; k++)
      r[k] = (m_pact != 0) && ((m_dact[k] >= m_pact) || (c < m_dact[k]));
    v = clk_enable && ((m_pact == 0) || (m_pos == 0));
`ifdef FOC_PWM_DEADTIME_EN
    m_hist.push_back(r);
    if (m_hist.size() > D + 1) void'(m_hist.pop_front());
`endif
    for (int k = 0; k < NP; k++) begin
      ok = 1'b1;
`ifdef FOC_PWM_DEADTIME_EN
      // A gate may drive only once raw has held its level for D+1 samples.
      ok = (m_hist.size() == D + 1);
      foreach (m_hist[j]) if (m_hist[j][k] != r[k]) ok = 1'b0;
`endif
      m_gh[k] = pwm_enable && ok && r[k];
      m_gl[k] = pwm_enable && ok && !r[k];
    end
    m_ce = v;
    if (v) begin
      m_pact = int'(period);
      for (int k = 0; k < NP; k++)
        m_dact[k] = duty_load ? duty_word(k) : m_shadow[k];
      m_pos = (m_pact == 0) ? 0 : 1;
    end else if (clk_enable && m_pact != 0) begin
      m_pos = (m_pos + 1) % (2*m_pact);
    end
    if (duty_load)
      for (int k = 0; k < NP; k++) m_shadow[k] = duty_word(k);
  endtask

  // Advance one clock; outputs are compared 1 ns after the active edge.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic set_duty(input int d0, input int d1, input int d2);
    logic [W-1:0] a, b, c;
    a = W'(d0); b = W'(d1); c = W'(d2);
    duty = {c, b, a};
  endtask

  // Shoot-through must never be visible on any phase.
  always @(negedge clk) begin
    n_checks++;
    if ((gate_hi & gate_lo) !== '0) begin
      n_fail++;
      $display("FAIL overlap t=%0t: gate_hi=%b gate_lo=%b must share no bit", $time, gate_hi, gate_lo);
    end
  end

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; clk_enable = 1'b1; pwm_enable = 1'b1;
    period = '0; duty = '0; duty_load = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (gate_hi !== 3'b000 || gate_lo !== 3'b000 || ce_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: hi=%b lo=%b ce=%b required all 0", gate_hi, gate_lo, ce_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int last_ce;
    int ph0_hi, ph2_lo;
    period = 10'd10; set_duty(0, 5, 10); duty_load = 1'b1;
    last_ce = -1; ph0_hi = 0; ph2_lo = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      duty_load = 1'b0;
      n_checks++;
      if (gate_hi !== m_gh || gate_lo !== m_gl || ce_out !== m_ce) begin
        n_fail++;
        $display("FAIL basic c%0d: hi=%b lo=%b ce=%b required hi=%b lo=%b ce=%b", i, gate_hi, gate_lo, ce_out, m_gh, m_gl, m_ce);
      end
      if (ce_out === 1'b1) begin
        if (last_ce >= 0) begin
          n_checks++;
          if (i - last_ce != 20) begin
            n_fail++;
            $display("FAIL basic_ce_interval: got %0d clks required 20", i - last_ce);
          end
        end
        last_ce = i;
      end
      if (i >= 2) begin
        if (gate_hi[0] === 1'b1) ph0_hi++;
        if (gate_lo[2] === 1'b1) ph2_lo++;
      end
    end
    n_checks++;
    if (ph0_hi != 0 || ph2_lo != 0) begin
      n_fail++;
      $display("FAIL basic_extremes: ph0 hi cycles=%0d ph2 lo cycles=%0d required 0 and 0", ph0_hi, ph2_lo);
    end
  endtask

  task automatic test_mid_change();
    int budget;
    budget = 0;
    while (!(m_pact == 10 && m_pos == 7) && budget < 100) begin
      tick();
      budget++;
    end
    n_checks++;
    if (budget >= 100) begin
      n_fail++;
      $display("FAIL mid_change_wait: carrier never reached cnt=7 rising within 100 clks");
    end
    set_duty($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12));
    duty_load = 1'b1;
    for (int i = 0; i < 45; i++) begin
      tick();
      duty_load = 1'b0;
      n_checks++;
      if (gate_hi !== m_gh || gate_lo !== m_gl || ce_out !== m_ce) begin
        n_fail++;
        $display("FAIL mid_change c%0d: hi=%b lo=%b ce=%b required hi=%b lo=%b ce=%b", i, gate_hi, gate_lo, ce_out, m_gh, m_gl, m_ce);
      end
    end
  endtask

  task automatic test_clk_enable_toggle();
    int p, last_ce, n_ce;
    logic prev_ce;
    p = $urandom_range(3, 8);
    period = W'(p);
    last_ce = -1; n_ce = 0; prev_ce = 1'b0;
    for (int i = 0; i < 16*p + 40; i++) begin
      clk_enable = i[0];
      tick();
      n_checks++;
      if (gate_hi !== m_gh || gate_lo !== m_gl || ce_out !== m_ce) begin
        n_fail++;
        $display("FAIL clk_en_toggle c%0d: hi=%b lo=%b ce=%b required hi=%b lo=%b ce=%b", i, gate_hi, gate_lo, ce_out, m_gh, m_gl, m_ce);
      end
      n_checks++;
      if (prev_ce === 1'b1 && ce_out === 1'b1) begin
        n_fail++;
        $display("FAIL clk_en_ce_width: ce_out high 2 clks in a row, required 1");
      end
      prev_ce = ce_out;
      if (ce_out === 1'b1) begin
        n_ce++;
        // From the third pulse on the new period is in force.
        if (n_ce >= 3) begin
          n_checks++;
          if (i - last_ce != 4*p) begin
            n_fail++;
            $display("FAIL clk_en_interval: got %0d clks required %0d", i - last_ce, 4*p);
          end
        end
        last_ce = i;
      end
    end
    clk_enable = 1'b1;
  endtask

  task automatic test_pwm_disable();
    int budget;
    period = 10'd10; set_duty(0, 6, 10); duty_load = 1'b1;
    tick();
    duty_load = 1'b0;
    budget = 0;
    while (!(m_dact[1] == 6 && m_pact == 10 && m_gh[1] === 1'b1) && budget < 120) begin
      tick();
      budget++;
    end
    n_checks++;
    if (budget >= 120) begin
      n_fail++;
      $display("FAIL pwm_disable_wait: phase 1 high pulse not reached within 120 clks");
    end
    pwm_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (gate_hi !== 3'b000 || gate_lo !== 3'b000 || ce_out !== m_ce) begin
        n_fail++;
        $display("FAIL pwm_disable c%0d: hi=%b lo=%b ce=%b required hi=000 lo=000 ce=%b", i, gate_hi, gate_lo, ce_out, m_ce);
      end
    end
    pwm_enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_checks++;
      if (gate_hi !== m_gh || gate_lo !== m_gl || ce_out !== m_ce) begin
        n_fail++;
        $display("FAIL pwm_resume c%0d: hi=%b lo=%b ce=%b required hi=%b lo=%b ce=%b", i, gate_hi, gate_lo, ce_out, m_gh, m_gl, m_ce);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      clk_enable = ($urandom_range(0, 3) != 0);
      pwm_enable = ($urandom_range(0, 7) != 0);
      duty_load  = ($urandom_range(0, 5) == 0);
      period     = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(1, 15));
      set_duty($urandom_range(0, 17), $urandom_range(0, 17), $urandom_range(0, 17));
      tick();
      n_checks++;
      if (gate_hi !== m_gh || gate_lo !== m_gl || ce_out !== m_ce) begin
        n_fail++;
        $display("FAIL random c%0d: hi=%b lo=%b ce=%b required hi=%b lo=%b ce=%b", i, gate_hi, gate_lo, ce_out, m_gh, m_gl, m_ce);
      end
    end
    clk_enable = 1'b1; pwm_enable = 1'b1; duty_load = 1'b0;
  endtask

`ifdef FOC_PWM_DEADTIME_EN
  task automatic test_deadtime();
    int off_run;
    bit seen_on;
    period = 10'd20; set_duty(10, 10, 10); duty_load = 1'b1;
    off_run = 0; seen_on = 1'b0;
    for (int i = 0; i < 160; i++) begin
      tick();
      duty_load = 1'b0;
      n_checks++;
      if (gate_hi !== m_gh || gate_lo !== m_gl || ce_out !== m_ce) begin
        n_fail++;
        $display("FAIL deadtime c%0d: hi=%b lo=%b ce=%b required hi=%b lo=%b ce=%b", i, gate_hi, gate_lo, ce_out, m_gh, m_gl, m_ce);
      end
      if (gate_hi[0] === 1'b0 && gate_lo[0] === 1'b0) begin
        off_run++;
      end else begin
        if (seen_on && off_run != 0 && i > 45) begin
          n_checks++;
          if (off_run != D) begin
            n_fail++;
            $display("FAIL deadtime_gap: both-off gap %0d clks required %0d", off_run, D);
          end
        end
        seen_on = 1'b1;
        off_run = 0;
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    int budget;
    period = 10'd10; set_duty(0, 5, 10); duty_load = 1'b1;
    tick();
    duty_load = 1'b0;
    budget = 0;
    while (!(m_pact == 10 && m_pos == 14 && m_dact[0] == 0) && budget < 120) begin
      tick();
      budget++;
    end
    n_checks++;
    if (budget >= 120) begin
      n_fail++;
      $display("FAIL reset_mid_wait: cnt=6 falling not reached within 120 clks");
    end
    // Mid-cycle, away from any edge: outputs must drop without a clock.
    rst = 1'b1;
    model_reset();
    #2;
    n_checks++;
    if (gate_hi !== 3'b000 || gate_lo !== 3'b000 || ce_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: hi=%b lo=%b ce=%b required all 0", gate_hi, gate_lo, ce_out);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (ce_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_valley: ce_out=%b required 1", ce_out);
    end
    for (int i = 0; i < 25; i++) begin
      tick();
      n_checks++;
      if (gate_hi !== m_gh || gate_lo !== m_gl || ce_out !== m_ce) begin
        n_fail++;
        $display("FAIL reset_resume c%0d: hi=%b lo=%b ce=%b required hi=%b lo=%b ce=%b", i, gate_hi, gate_lo, ce_out, m_gh, m_gl, m_ce);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mid_change();
    test_clk_enable_toggle();
    test_pwm_disable();
`ifdef FOC_PWM_DEADTIME_EN
    test_deadtime();
`endif
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded 1 ms");
    $fatal(1, "timeout");
  end

endmodule
